// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of a 5-stage RV32I pipeline. Commits
//               byte-enabled stores into a synchronous-read data memory,
//               issues loads, and registers writeback-bound data and control
//               into the MEM/WB pipeline register.
// Ports       : i_clk, i_rst_n       - clock, synchronous active-low reset
//               i_stall, i_flush     - hold / bubble the MEM/WB register
//               i_valid .. i_rd_wren - EX/MEM instruction fields
//               o_valid .. o_rd_wren - MEM/WB register outputs
//               o_ld_data            - raw aligned memory word (1-cycle read)
//               o_misaligned         - misaligned access flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int DMEM_DEPTH = 2048,
  parameter int AW         = 11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_st_data,
  input  logic        i_mem_wren,
  input  logic        i_mem_rden,
  input  logic [1:0]  i_st_size,
  input  logic [2:0]  i_ld_rewrite,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_pc_four,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_rd_wren,
  output logic        o_valid,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_pc_four,
  output logic [1:0]  o_wb_sel,
  output logic [2:0]  o_ld_rewrite,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic        o_misaligned
);

  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;
  localparam logic [1:0] c_size_rsvd = 2'd3;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic [1:0]    w_ld_size;
  logic [1:0]    w_size;
  logic          w_mis;
  logic          w_memop;
  logic          w_adv;
  logic          w_st_commit;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;

  assign w_idx      = i_alu_data[AW+1:2];
  assign w_in_range = (i_alu_data[31:AW+2] == '0);
  assign w_memop    = i_mem_wren | i_mem_rden;
  assign w_adv      = i_rst_n & ~i_stall & ~i_flush;

  // Access width of a load, recovered from its rewrite code.
  always_comb begin
    w_ld_size = c_size_byte;
    case (i_ld_rewrite)
      3'd1, 3'd4: w_ld_size = c_size_half;
      3'd2:       w_ld_size = c_size_word;
      default:    w_ld_size = c_size_byte;
    endcase
  end

  assign w_size = i_mem_wren ? i_st_size : w_ld_size;
  assign w_mis  = ((w_size == c_size_half) & i_alu_data[0]) |
                  ((w_size == c_size_word) & (i_alu_data[1:0] != 2'b00));

  assign w_st_commit = w_adv & i_valid & i_mem_wren & w_in_range & ~w_mis &
                       (i_st_size != c_size_rsvd);

  // Replicate the store data so every enabled lane sees its correct byte.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_st_data;
    case (i_st_size)
      c_size_byte: begin
        w_be    = 4'b0001 << i_alu_data[1:0];
        w_wdata = {4{i_st_data[7:0]}};
      end
      c_size_half: begin
        w_be    = i_alu_data[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_st_data[15:0]}};
      end
      c_size_word: begin
        w_be    = 4'b1111;
        w_wdata = i_st_data;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = i_st_data;
      end
    endcase
  end

  // One byte-wide memory per lane; the read register only advances with
  // the MEM/WB register so a stalled load keeps its captured word.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DMEM_DEPTH];
    logic [7:0] r_ld_byte;

    always_ff @(posedge i_clk) begin
      if (w_st_commit && w_be[g]) begin
        r_mem[w_idx] <= w_wdata[8*g +: 8];
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_ld_byte <= 8'h00;
      end else if (i_flush) begin
        r_ld_byte <= 8'h00;
      end else if (!i_stall) begin
        r_ld_byte <= w_in_range ? r_mem[w_idx] : 8'h00;
      end
    end

    assign o_ld_data[8*g +: 8] = r_ld_byte;
  end

  logic        r_valid;
  logic [31:0] r_alu_data;
  logic [31:0] r_pc_four;
  logic [1:0]  r_wb_sel;
  logic [2:0]  r_ld_rewrite;
  logic [4:0]  r_rd_addr;
  logic        r_rd_wren;
  logic        r_misaligned;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_valid      <= 1'b0;
      r_alu_data   <= 32'h0;
      r_pc_four    <= 32'h0;
      r_wb_sel     <= 2'd0;
      r_ld_rewrite <= 3'd0;
      r_rd_addr    <= 5'd0;
      r_rd_wren    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (!i_stall) begin
      r_valid      <= i_valid;
      r_alu_data   <= i_alu_data;
      r_pc_four    <= i_pc_four;
      r_wb_sel     <= i_wb_sel;
      r_ld_rewrite <= i_ld_rewrite;
      r_rd_addr    <= i_rd_addr;
      // A misaligned memory access never writes the register file.
      r_rd_wren    <= i_valid & i_rd_wren & ~(w_mis & w_memop);
      r_misaligned <= i_valid & w_mis & w_memop;
    end
  end

  assign o_valid      = r_valid;
  assign o_alu_data   = r_alu_data;
  assign o_pc_four    = r_pc_four;
  assign o_wb_sel     = r_wb_sel;
  assign o_ld_rewrite = r_ld_rewrite;
  assign o_rd_addr    = r_rd_addr;
  assign o_rd_wren    = r_rd_wren;
  assign o_misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM boundary and the writeback stage. Performs stores into a byte-enabled, synchronous-read data memory and issues loads. Registers all writeback-bound control and data into the MEM/WB pipeline register. Outputs feed the writeback stage directly:
- o_ld_data is the raw aligned 32-bit word.
- Byte/half extraction and sign extension stay in writeback, selected by o_ld_rewrite and o_alu_data[1:0].

Parameters:
DMEM_DEPTH, 2048, data memory depth in 32-bit words (8 KiB; valid byte addresses 0x0000-0x1FFF)
AW, 11, word-index width, equal to log2(DMEM_DEPTH)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous reset, active-low
i_stall  in  1  hold MEM/WB register and suppress store commit
i_flush  in  1  load a bubble into MEM/WB and suppress store commit
i_valid  in  1  EX/MEM holds a real instruction
i_alu_data  in  32  ALU result / effective byte address
i_st_data  in  32  store data (rs2)
i_mem_wren  in  1  instruction is a store
i_mem_rden  in  1  instruction is a load
i_st_size  in  2  0=SB, 1=SH, 2=SW, 3=reserved (treated as no store)
i_ld_rewrite  in  3  load type, passed through (0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU)
i_wb_sel  in  2  writeback select, passed through
i_pc_four  in  32  PC+4, passed through
i_rd_addr  in  5  destination register
i_rd_wren  in  1  register-file write enable
o_valid  out  1  MEM/WB holds a real instruction
o_ld_data  out  32  raw memory word for the load address
o_alu_data  out  32  registered i_alu_data
o_pc_four  out  32  registered i_pc_four
o_wb_sel  out  2  registered i_wb_sel
o_ld_rewrite  out  3  registered i_ld_rewrite
o_rd_addr  out  5  registered i_rd_addr
o_rd_wren  out  1  registered write enable, gated
o_misaligned  out  1  access in MEM/WB was misaligned

Behaviour:
- Reset and gating terms:
  - On a clock edge with i_rst_n=0, every output becomes 0, including o_ld_data and o_misaligned.
  - Reset overrides stall and flush, and blocks any store on that edge.
  - Data memory contents are not reset.
  - adv = i_rst_n & ~i_stall & ~i_flush. Flush wins over stall.
- Addressing and alignment:
  - Word index = i_alu_data[AW+1:2].
  - in_range = (i_alu_data[31:AW+2] == 0).
  - mis = (size 1 & addr[0]) | (size 2 & addr[1:0] != 0). size is i_st_size for stores; for loads it is derived from i_ld_rewrite (LH/LHU→1, LW→2, byte→0).
- Store commit (memory write on the edge):
  - Condition: adv & i_valid & i_mem_wren & in_range & ~mis & i_st_size != 3.
  - SB: byte lane addr[1:0] written with st_data[7:0].
  - SH: lanes {addr[1],1'b1} and {addr[1],1'b0} written with st_data[15:0].
  - SW: all four lanes written.
  - Lanes not enabled are unchanged.
- Load timing:
  - Synchronous read, 1-cycle latency.
  - o_ld_data updates on the same edge the MEM/WB register advances, so it is aligned with o_alu_data.
  - in_range=0 gives o_ld_data=0.
  - Loads ignore mis for data but flag it.
  - A load on the cycle after a store to the same word returns the new data.
- Register update:
  - If adv: all o_* are loaded from inputs. o_valid=i_valid. o_rd_wren = i_valid & i_rd_wren & ~(mis & (i_mem_wren|i_mem_rden)). o_misaligned = i_valid & mis & (i_mem_wren|i_mem_rden).
  - If i_flush & i_rst_n: o_valid, o_rd_wren and o_misaligned go to 0. Other outputs are don't-care; the implementation clears them to 0.
  - If i_stall & ~i_flush: every output holds, including o_ld_data, which must be captured and not re-read.
- Non-memory instructions (i_mem_wren=i_mem_rden=0): no memory side effect. o_ld_data is don't-care.

Test Plan:
- Reset: i_rst_n=0 for 2 cycles with i_valid=1, i_rd_wren=1, i_alu_data=0x55 → all outputs 0 after the first edge.
- SW 0xAABBCCDD @0x100, then LW @0x100 (i_ld_rewrite=2, i_wb_sel=2) → next cycle o_ld_data=0xAABBCCDD, o_alu_data=0x100, o_wb_sel=2, o_rd_wren=1.
- SB st_data=0x12345611 @0x101, then LW @0x100 → o_ld_data=0xAABB11DD. SH 0x00007788 @0x102, then LW → 0x778811DD.
- SH @0x101 and SW @0x102 → o_misaligned=1, o_rd_wren=0. Memory unchanged: LW @0x100 still 0x778811DD.
- LW @0x100, then i_stall=1 for 3 cycles while an SW 0xFFFFFFFF @0x100 is presented → outputs frozen at 0x778811DD and memory not written. Flush with the SW present → o_valid=0, o_rd_wren=0, no write. Stall+flush together → bubble.
- LW @0x2000 (out of range) → o_ld_data=0. SW @0x2000 → no write, and LW @0x0 is unchanged.
